// File: rtl/icb_write_arbiter.sv
// icb_write_arbiter
// Round-robin arbiter that shares the single frame-buffer write port among
// the ICB requesters. It picks one requester per write, holds that write on
// the memory port until memory accepts it, then pulses a one-cycle grant.
//
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   req[N]               per-ICB write request (level)
//   req_addr[N*AW]       flattened addresses, requester i at [i*AW +: AW]
//   req_data[N*DW]       flattened pixel data, requester i at [i*DW +: DW]
//   clear                synchronous clear of wr_count and the rr pointer
//   mem_ready            memory accepts the presented write this cycle
//   mem_we/addr/wdata    registered write to the frame buffer
//   grant[N]             one-hot, one cycle, on acceptance
//   idle                 FSM in IDLE and no request pending
//   wr_count[16]         accepted writes since reset/clear (wraps)
module icb_write_arbiter #(
    parameter int N  = 30,
    parameter int AW = 18,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_data,
    input  logic            clear,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [N-1:0]    grant,
    output logic            idle,
    output logic [15:0]     wr_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic [IW:0]     cand;

    // Rotating priority search: examine ptr, ptr+1, ... wrapping at N, and
    // keep the first requester found.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!win_found && req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        grant   = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    addr_d  = req_addr[win_idx*AW +: AW];
                    wdata_d = req_data[win_idx*DW +: DW];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Latched write completes even if the requester dropped req.
                if (mem_ready) begin
                    grant[idx_q] = 1'b1;
                    ptr_d   = (idx_q == IW'(N-1)) ? '0 : idx_q + 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clear overrides the acceptance update but never aborts the write.
        if (clear) begin
            ptr_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // mem_we follows the state flop, so reset drops it asynchronously.
    assign mem_we    = (state_q == ISSUE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wr_count  = cnt_q;
    assign idle      = (state_q == IDLE) && (req == '0);

endmodule

// File: tb/tb_icb_write_arbiter.sv
module tb_icb_write_arbiter;

    localparam int N  = 30;
    localparam int AW = 18;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            clear;
    logic            mem_ready;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [N-1:0]    grant;
    logic            idle;
    logic [15:0]     wr_count;

    int total = 0;
    int bad   = 0;

    icb_write_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_addr(req_addr),
        .req_data(req_data), .clear(clear), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .grant(grant), .idle(idle), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; samples and drives happen 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0; req = '0; req_addr = '0; req_data = '0;
        clear = 1'b0; mem_ready = 1'b0;
        #12;
        chk("rst_we",    32'(mem_we), 0);
        chk("rst_addr",  32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_cnt",   32'(wr_count), 0);
        chk("rst_idle",  32'(idle), 1);
        step();
        n_rst = 1'b1;
        step();

        // Single request from ICB 5
        req = 30'(1) << 5;
        req_addr[5*AW +: AW] = 18'h12345;
        req_data[5*DW +: DW] = 8'hA7;
        mem_ready = 1'b1;
        #1;
        chk("single_idle", 32'(idle), 0);
        step();
        chk("single_we",    32'(mem_we), 1);
        chk("single_addr",  32'(mem_addr), 32'h12345);
        chk("single_data",  32'(mem_wdata), 32'hA7);
        chk("single_grant", 32'(grant), 32'h20);
        req = '0;
        step();
        chk("single_cnt",   32'(wr_count), 1);
        chk("single_ptr",   32'(dut.ptr_q), 6);
        chk("single_we0",   32'(mem_we), 0);
        chk("single_gnt0",  32'(grant), 0);

        // Full fairness from ptr 0
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_ptr", 32'(dut.ptr_q), 0);
        chk("clr_cnt", 32'(wr_count), 0);
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = AW'(i + 100);
            req_data[i*DW +: DW] = DW'(i);
        end
        req = '1;
        for (int k = 0; k < N + 1; k++) begin
            step();
            chk($sformatf("fair_gnt%0d", k), 32'(grant), 32'(30'(1) << (k % N)));
            chk($sformatf("fair_addr%0d", k), 32'(mem_addr), 32'((k % N) + 100));
            step();
            if (k == N - 1) chk("fair_cnt30", 32'(wr_count), 30);
        end
        req = '0;
        step();

        // Wrap and skip: bring ptr to 28 via a write from 27
        clear = 1'b1;
        step();
        clear = 1'b0;
        req = 30'(1) << 27;
        step();
        req = '0;
        step();
        chk("wrap_ptr28", 32'(dut.ptr_q), 28);
        req = (30'(1) << 29) | (30'(1) << 3);
        step();
        chk("wrap_gnt29", 32'(grant), 32'(30'(1) << 29));
        req = 30'(1) << 3;
        step();
        step();
        chk("wrap_gnt3", 32'(grant), 32'h8);
        req = '0;
        step();
        chk("wrap_ptr4", 32'(dut.ptr_q), 4);

        // Backpressure
        req = 30'(1) << 10;
        req_addr[10*AW +: AW] = 18'h3FFFF;
        req_data[10*DW +: DW] = 8'h55;
        mem_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_we%0d", c),   32'(mem_we), 1);
            chk($sformatf("bp_addr%0d", c), 32'(mem_addr), 32'h3FFFF);
            chk($sformatf("bp_data%0d", c), 32'(mem_wdata), 32'h55);
            chk($sformatf("bp_gnt%0d", c),  32'(grant), 0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("bp_gnt", 32'(grant), 32'(30'(1) << 10));
        req = '0;
        step();
        chk("bp_idle_gnt", 32'(grant), 0);
        chk("bp_idle_we",  32'(mem_we), 0);
        chk("bp_cnt",      32'(wr_count), 4);

        // Clear colliding with acceptance at wr_count 7
        clear = 1'b1;
        step();
        clear = 1'b0;
        req = 30'(1) << 1;
        for (int s = 0; s < 14; s++) step();
        chk("coll_cnt7", 32'(wr_count), 7);
        step();
        clear = 1'b1;
        #1;
        chk("coll_gnt", 32'(grant), 32'h2);
        step();
        clear = 1'b0;
        req = '0;
        chk("coll_cnt0", 32'(wr_count), 0);
        chk("coll_ptr0", 32'(dut.ptr_q), 0);
        chk("coll_we0",  32'(mem_we), 0);

        // Reset during a stalled write
        req = 30'(1) << 2;
        step();
        step();
        chk("pre_rst_cnt", 32'(wr_count), 1);
        mem_ready = 1'b0;
        step();
        chk("stall_we", 32'(mem_we), 1);
        req = '0;
        #2;
        n_rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_mid_we",  32'(mem_we), 0);
        chk("rst_mid_gnt", 32'(grant), 0);
        step();
        n_rst = 1'b1;
        step();
        chk("post_rst_we",   32'(mem_we), 0);
        chk("post_rst_idle", 32'(idle), 1);
        chk("post_rst_cnt",  32'(wr_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icb_write_arbiter.md
# icb_write_arbiter

Round-robin arbiter that shares the single frame-buffer write port among the ICB slave array. Each ICB presents a request with a pixel address and colour once its calculation completes. The arbiter picks one requester at a time, holds the write on the memory port until memory accepts it, and returns a one-cycle grant to the winner. It sits between the ICB array outputs and the frame-buffer write interface, alongside the master controller.

## Interface
- N, 30, number of ICB requesters
- AW, 18, write address width (9-bit x, 9-bit y)
- DW, 8, pixel data width
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- req  in  N  per-ICB write request, level
- req_addr  in  N*AW  flattened addresses; requester i owns bits [i*AW +: AW]
- req_data  in  N*DW  flattened pixel data; requester i owns bits [i*DW +: DW]
- clear  in  1  synchronous clear of wr_count and rr pointer
- mem_ready  in  1  memory accepts the current write this cycle
- mem_we  out  1  write valid to frame buffer
- mem_addr  out  AW  registered write address
- mem_wdata  out  DW  registered write data
- grant  out  N  one-hot, one cycle, marks the requester whose write was accepted
- idle  out  1  arbiter in IDLE and no req bit set
- wr_count  out  16  number of accepted writes since reset/clear

## Operation
- The FSM has two states: IDLE and ISSUE. Reset state is IDLE.
- Round-robin pointer ptr (0..N-1), reset 0.
- IDLE, req != 0: the winner is the first set req bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1. The arbiter latches winner index, req_addr slice and req_data slice into the output registers, then moves to ISSUE.
- IDLE, req == 0: stays in IDLE. Outputs hold their last values with mem_we = 0.
- ISSUE: mem_we = 1. mem_addr and mem_wdata stay stable until acceptance.
- ISSUE, mem_ready = 1: the write is accepted. grant[idx] = 1 combinationally in the same cycle. ptr <= (idx == N-1) ? 0 : idx+1. wr_count increments. The FSM returns to IDLE.
- ISSUE, mem_ready = 0: stays in ISSUE. There is no timeout.
- Requester protocol: hold req, addr and data until its grant cycle. It may keep req high for a further write with new data from the next cycle.
- If req[idx] drops while in ISSUE, the latched write still completes and grant[idx] still pulses. Requests are not cancelled.
- clear: ptr <= 0 and wr_count <= 0 on the next edge. It does not abort an in-flight ISSUE.
- clear together with acceptance: clear wins, so wr_count = 0 and ptr = 0. The write itself still completes and grant still pulses.
- wr_count is 16 bits and wraps from 65535 to 0.
- idle = (state == IDLE) && (req == 0). It is combinational.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, grant 0, wr_count 0, idle 1 if req == 0.
- Reset mid-ISSUE drops mem_we to 0 asynchronously. The pending write is lost and no grant is issued.
- Latency from req rising (in IDLE) to mem_we high is 1 cycle.
- Acceptance takes the first edge with mem_we && mem_ready. The minimum is 1 cycle after mem_we rises.
- Throughput is at most one write per 2 cycles, because IDLE is always visited between writes.
- grant is never asserted outside ISSUE && mem_ready. At most one grant bit is set.
- With all N requesting continuously, each requester is served exactly once per N writes.

## Test plan
- Single request: req = 1<<5, addr5 = 0x1_2345, data5 = 0xA7, mem_ready tied 1 -> mem_we high in cycle 1 with mem_addr 0x12345 and mem_wdata 0xA7. grant = 1<<5 in the same cycle. wr_count = 1. ptr = 6.
- Full fairness: all 30 req high, mem_ready = 1, ptr = 0 -> grants in order 0,1,…,29,0, one every 2 cycles. wr_count = 30 after 60 cycles.
- Wrap and skip: ptr = 28, req = bits {3, 29} -> grant 29 first, then 3. ptr ends at 4.
- Backpressure: mem_ready low for 5 cycles during ISSUE -> mem_we, mem_addr and mem_wdata stable for all 5 cycles with grant = 0. Grant appears on the first cycle mem_ready = 1.
- Clear collision: clear and acceptance in the same cycle with wr_count = 7 -> the grant pulses, then wr_count = 0 and ptr = 0.
- Reset mid-ISSUE: n_rst low while mem_we = 1 and mem_ready = 0 -> mem_we drops immediately with no grant. After release the arbiter is in IDLE with wr_count = 0.
